// File: rtl/des_f_function_seq_if.sv
// Handshake bundle for the sequential DES f-function stage.
// The slave modport is the stage; the master modport is the round logic driving it.
interface des_f_function_seq_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_r;
    logic [47:0] i_subkey;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_f;

    modport slave  (input  i_valid, i_r, i_subkey, i_ready,
                    output o_ready, o_valid, o_f);
    modport master (output i_valid, i_r, i_subkey, i_ready,
                    input  o_ready, o_valid, o_f);
endinterface

// File: rtl/des_f_function_seq.sv
// Sequential DES round function: E-expand and key-mix in one cycle, then eight
// one-per-cycle S-box lookups, then the P permutation behind a valid/ready output.
module des_f_function_seq (
    input  logic                        i_clk,
    input  logic                        i_rst,
    des_f_function_seq_if.slave         bus
);
    localparam int E_TBL [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                                  8, 9,10,11,12,13,12,13,14,15,16,17,
                                 16,17,18,19,20,21,20,21,22,23,24,25,
                                 24,25,26,27,28,29,28,29,30,31,32, 1};
    localparam int P_TBL [32] = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                                   2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};

    // Each table holds 64 nibbles, row-major, entry 0 in the top nibble.
    localparam logic [255:0] S1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

    function automatic logic [47:0] f_expand(input logic [31:0] r);
        logic [47:0] e;
        e = '0;
        for (int n = 1; n <= 48; n++) e[48-n] = r[32-E_TBL[n-1]];
        return e;
    endfunction

    function automatic logic [31:0] f_perm(input logic [31:0] s);
        logic [31:0] p;
        p = '0;
        for (int n = 1; n <= 32; n++) p[32-n] = s[32-P_TBL[n-1]];
        return p;
    endfunction

    function automatic logic [3:0] f_sbox(input logic [2:0] box, input logic [5:0] c);
        logic [255:0] t;
        logic [5:0]   idx;
        case (box)
            3'd0:    t = S1;
            3'd1:    t = S2;
            3'd2:    t = S3;
            3'd3:    t = S4;
            3'd4:    t = S5;
            3'd5:    t = S6;
            3'd6:    t = S7;
            default: t = S8;
        endcase
        idx = {c[5], c[0], c[4:1]};
        return t[255 - 4*int'(idx) -: 4];
    endfunction

    state_t      r_state;
    logic [47:0] r_x;
    logic [2:0]  r_n;
    logic [31:0] r_s;
    logic [31:0] r_f;
    logic        r_valid;
    logic [3:0]  w_nib;
    logic [31:0] w_s_next;

    // x and s_acc are kept as shift registers: the live chunk is always x[47:42]
    // and nibbles enter s_acc from the bottom, so after eight steps S1 lands on top.
    always_comb begin
        w_nib    = f_sbox(r_n, r_x[47:42]);
        w_s_next = {r_s[27:0], w_nib};
    end

    assign bus.o_ready = (r_state == IDLE) && !i_rst;
    assign bus.o_valid = r_valid;
    assign bus.o_f     = r_f;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_n     <= '0;
            r_s     <= '0;
            r_f     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_x     <= f_expand(bus.i_r) ^ bus.i_subkey;
                        r_n     <= '0;
                        r_s     <= '0;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_x <= r_x << 6;
                    r_s <= w_s_next;
                    r_n <= r_n + 3'd1;
                    if (r_n == 3'd7) begin
                        r_f     <= f_perm(w_s_next);
                        r_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_f_function_seq.sv
// Scoreboard bench for the sequential DES f-function: expected f values are
// queued at accept time from a behavioural model and compared on consume.
module tb_des_f_function_seq;
    logic clk;
    logic rst;
    des_f_function_seq_if bus();

    des_f_function_seq dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    int ET [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
    int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    int SB [512] = '{
        14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,      0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
        4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,      15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
        15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,      3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
        0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,      13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
        10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,      13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
        13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,      1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
        7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,      13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
        10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,      3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
        2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,      14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
        4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,      11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
        12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,      10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
        9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,      4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
        4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,      13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
        1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,      6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
        13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,      1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
        7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,      2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

    function automatic logic [31:0] model_f(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s, p;
        logic [5:0]  c;
        int          row, col;
        x = '0; s = '0; p = '0;
        for (int n = 1; n <= 48; n++) x[48-n] = r[32-ET[n-1]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            c   = x[47-6*b -: 6];
            row = {c[5], c[0]};
            col = c[4:1];
            s[31-4*b -: 4] = 4'(SB[b*64 + row*16 + col]);
        end
        for (int n = 1; n <= 32; n++) p[32-n] = s[32-PT[n-1]];
        return p;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [31:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
        checks++; if (bus.o_f !== 32'h0) begin errors++; $display("FAIL reset_f got=%h exp=0", bus.o_f); end
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_in_rst got=%b exp=0", bus.o_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got=%b exp=1", bus.o_ready); end
    endtask

    task automatic test_fips;
        logic [31:0] e;
        int lat;
        bit both;
        bus.i_r = 32'hF0AAF0AA; bus.i_subkey = 48'h1B02EFFC7072;
        bus.i_ready = 1'b1; bus.i_valid = 1'b1;
        exp_q.push_back(32'h234AA9BB);
        tick();
        bus.i_valid = 1'b0; bus.i_r = 32'hDEADBEEF; bus.i_subkey = '1;
        lat = 0; both = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.o_valid && bus.o_ready) both = 1;
            if (bus.o_valid === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 8) begin errors++; $display("FAIL fips_latency got=%0d exp=8", lat); end
        checks++; if (both) begin errors++; $display("FAIL fips_ready_valid_overlap got=1 exp=0"); end
        pop_exp(e);
        checks++; if (bus.o_f !== e) begin errors++; $display("FAIL fips_f got=%h exp=%h", bus.o_f, e); end
        tick();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1)
            begin errors++; $display("FAIL fips_consume got valid=%b ready=%b exp valid=0 ready=1", bus.o_valid, bus.o_ready); end
    endtask

    task automatic test_zero;
        logic [31:0] e;
        int low_cnt;
        bus.i_r = '0; bus.i_subkey = '0; bus.i_ready = 1'b1; bus.i_valid = 1'b1;
        exp_q.push_back(model_f(32'h0, 48'h0));
        tick();
        bus.i_valid = 1'b0;
        low_cnt = 0;
        for (int c = 1; c <= 9; c++) begin
            if (bus.o_ready === 1'b0) low_cnt++;
            if (c < 9) tick();
        end
        checks++; if (low_cnt != 9) begin errors++; $display("FAIL zero_ready_low got=%0d exp=9", low_cnt); end
        pop_exp(e);
        checks++; if (bus.o_valid !== 1'b1 || bus.o_f !== e)
            begin errors++; $display("FAIL zero_f got valid=%b f=%h exp valid=1 f=%h", bus.o_valid, bus.o_f, e); end
        tick();
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL zero_ready_after got=%b exp=1", bus.o_ready); end
    endtask

    task automatic test_backpressure;
        logic [31:0] e;
        int bad, lat;
        bus.i_r = 32'hF0AAF0AA; bus.i_subkey = 48'h1B02EFFC7072;
        bus.i_ready = 1'b0; bus.i_valid = 1'b1;
        exp_q.push_back(model_f(32'hF0AAF0AA, 48'h1B02EFFC7072));
        tick();
        bus.i_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.o_valid === 1'b1) begin lat = c; break; end
        end
        checks++; if (lat != 8) begin errors++; $display("FAIL bp_latency got=%0d exp=8", lat); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            bus.i_valid = c[0];
            bus.i_r = $urandom;
            tick();
            if (bus.o_f !== 32'h234AA9BB || bus.o_valid !== 1'b1 || bus.o_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles exp=0 (f=%h)", bad, bus.o_f); end
        pop_exp(e);
        checks++; if (bus.o_f !== e) begin errors++; $display("FAIL bp_f got=%h exp=%h", bus.o_f, e); end
        bus.i_valid = 1'b0; bus.i_ready = 1'b1;
        tick();
        checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
            begin errors++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", bus.o_ready, bus.o_valid); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] e, r;
        logic [47:0] k;
        int rises, lat;
        bus.i_r = $urandom; bus.i_subkey = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
        bus.i_ready = 1'b1; bus.i_valid = 1'b1;
        exp_q.push_back(model_f(bus.i_r, bus.i_subkey));
        tick();
        bus.i_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(exp_q.pop_back());
        tick();
        checks++; if (bus.o_valid !== 1'b0 || bus.o_f !== 32'h0 || bus.o_ready !== 1'b1)
            begin errors++; $display("FAIL mid_rst_state got valid=%b f=%h ready=%b exp 0 0 1", bus.o_valid, bus.o_f, bus.o_ready); end
        rises = 0;
        for (int c = 0; c < 12; c++) begin tick(); if (bus.o_valid !== 1'b0) rises++; end
        checks++; if (rises != 0) begin errors++; $display("FAIL mid_rst_no_valid got=%0d exp=0", rises); end
        r = $urandom; k = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
        bus.i_r = r; bus.i_subkey = k; bus.i_valid = 1'b1;
        exp_q.push_back(model_f(r, k));
        tick();
        bus.i_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.o_valid === 1'b1) begin lat = c; break; end
        end
        pop_exp(e);
        checks++; if (lat != 8 || bus.o_f !== e)
            begin errors++; $display("FAIL mid_rst_next got lat=%0d f=%h exp lat=8 f=%h", lat, bus.o_f, e); end
        tick();
    endtask

    task automatic test_back_to_back;
        logic [31:0] e;
        int accepts, outs, last_acc, cyc;
        bit acc_now;
        accepts = 0; outs = 0; last_acc = -1; cyc = 0;
        bus.i_ready = 1'b1; bus.i_valid = 1'b1;
        bus.i_r = $urandom; bus.i_subkey = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
        while ((accepts < 100 || outs < 100) && cyc < 3000) begin
            acc_now = 0;
            if (bus.o_ready === 1'b1 && bus.i_valid) begin
                exp_q.push_back(model_f(bus.i_r, bus.i_subkey));
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 10)
                        begin errors++; $display("FAIL b2b_spacing got=%0d exp=10", cyc - last_acc); end
                end
                last_acc = cyc; accepts++; acc_now = 1;
            end
            if (bus.o_valid === 1'b1) begin
                pop_exp(e);
                checks++; if (bus.o_f !== e) begin errors++; $display("FAIL b2b_f[%0d] got=%h exp=%h", outs, bus.o_f, e); end
                outs++;
            end
            tick();
            cyc++;
            if (acc_now) begin
                bus.i_r = $urandom; bus.i_subkey = {$urandom, $urandom} & 48'hFFFFFFFFFFFF;
                if (accepts == 100) bus.i_valid = 1'b0;
            end
        end
        checks++; if (accepts != 100 || outs != 100)
            begin errors++; $display("FAIL b2b_count got acc=%0d out=%0d exp 100 100", accepts, outs); end
    endtask

    initial begin
        rst = 1'b1;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0; bus.i_r = '0; bus.i_subkey = '0;
        test_reset();
        test_fips();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/des_f_function_seq.md
# des_f_function_seq

Sequential DES round-function (f) stage wrapping the eight S-box lookup modules (S_Box_1 … S_Box_8). It accepts the 32-bit right half R and the 48-bit round subkey K and computes E(R) XOR K. It then feeds one 6-bit chunk per cycle to the matching S-box, collects the 32-bit substitution result, and applies the P permutation. The f output goes to the round's Feistel XOR through a valid/ready handshake, so one small S-box mux serves all eight lookups.

## Interface
- Parameters: none.
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream R/K pair valid.
- o_ready  output  1  stage can accept a new pair (IDLE state only).
- i_r  input  32  right half R; bit 31 = DES bit 1.
- i_subkey  input  48  round subkey K; bit 47 = DES bit 1.
- o_valid  output  1  o_f valid; held until consumed.
- i_ready  input  1  downstream accepts o_f.
- o_f  output  32  f(R,K); bit 31 = DES bit 1.

## Operation
- Bit numbering: DES bit n maps to vector bit (width − n).
- E table, output bits 1..48 taken from R bits: 32 1 2 3 4 5 4 5 6 7 8 9 8 9 10 11 12 13 12 13 14 15 16 17 16 17 18 19 20 21 20 21 22 23 24 25 24 25 26 27 28 29 28 29 30 31 32 1.
- P table, output bits 1..32 taken from S-output bits: 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
- States: IDLE, LOOKUP, DONE.
- IDLE:
  - o_ready = 1.
  - On i_valid=1, register x = E(i_r) XOR i_subkey, clear 3-bit counter n, clear s_acc, go to LOOKUP.
- LOOKUP:
  - Chunk x[47−6n −: 6] is applied unmodified to S_Box_(n+1). The S-box module does row/column decoding internally.
  - Its 4-bit result is written to s_acc[31−4n −: 4].
  - n increments each cycle.
  - At n=7: write the last nibble, register o_f = P(s_acc with final nibble), set o_valid, go to DONE.
- DONE:
  - o_valid = 1, o_f stable.
  - On i_ready=1, clear o_valid and go to IDLE.
  - i_valid is ignored outside IDLE. Inputs need not be held after acceptance.
- n wraps 7→0 only through the state transition. It is never observed outside LOOKUP.

## Timing
- Reset (i_rst=1 at an edge):
  - State becomes IDLE; o_valid=0, o_f=0, x=0, s_acc=0, n=0.
  - o_ready is forced 0 while i_rst is high and becomes 1 in the first cycle after reset deasserts.
- Reset mid-LOOKUP or in DONE aborts the operation. No o_valid pulse follows.
- Acceptance at edge k (IDLE, i_valid=1, i_rst=0):
  - Lookups occur at edges k+1..k+8.
  - o_valid rises after edge k+8, so latency is 8 cycles from the accept edge to visible o_valid.
- Consume edge j (DONE, i_ready=1): o_valid falls and o_ready rises after edge j. There is no same-edge re-accept. Minimum issue interval is 10 cycles.
- i_ready=1 while not in DONE has no effect. i_ready held high gives a single-cycle o_valid pulse.
- Simultaneous i_rst and a handshake: reset wins.
- o_ready and o_valid are never both 1.

## Test plan
- FIPS round-1 vector:
  - Stimulus: i_r=F0AAF0AA, i_subkey=1B02EFFC7072, i_ready=1.
  - Internal x=6117BA866527, S-output 5C82B597.
  - Required: o_f=234AA9BB with o_valid exactly 8 cycles after accept.
- Zero vector:
  - Stimulus: i_r=0, i_subkey=0.
  - S-output EFA72C4D.
  - Required: o_f = P(EFA72C4D), checked against the reference model; o_ready low for cycles 1–9 after accept.
- Backpressure:
  - Stimulus: FIPS vector with i_ready=0 for 20 cycles after o_valid, and i_valid toggling with a new R.
  - Required: o_f held at 234AA9BB and no new accept; after i_ready=1, o_ready=1 the next cycle.
- Reset mid-operation:
  - Stimulus: assert i_rst at lookup cycle 4.
  - Required: o_valid never rises, o_f=0, o_ready=1 one cycle after deassert; the next vector computes correctly.
- Back-to-back:
  - Stimulus: i_valid and i_ready held high, 100 random R/K pairs.
  - Required: all o_f values match the model, in order; accepts spaced exactly 10 cycles.
